// File: rtl/signed_divider.sv
// signed_divider: 8-bit restoring shift-subtract signed divider with Start/Done handshake
module signed_divider (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       Done,
  output logic       Busy,
  output logic       DivByZero,
  output logic       Overflow
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t     state;
  logic       sd, sv, dz, ovf;
  logic [7:0] mq, md, r, dvd;
  logic [2:0] cnt;
  logic [8:0] rs, t;
  // trial subtraction of the divisor magnitude from the shifted partial remainder;
  // r never exceeds md, so its ninth bit is always zero and is not stored
  always_comb begin
    rs = {r, mq[7]};
    t  = rs - {1'b0, md};
  end
  // control, iteration datapath and registered result/status outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      sd        <= 1'b0;
      sv        <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      mq        <= 8'h00;
      md        <= 8'h00;
      r         <= 8'h00;
      dvd       <= 8'h00;
      cnt       <= 3'd0;
      Quotient  <= 8'h00;
      Remainder <= 8'h00;
      Done      <= 1'b0;
      Busy      <= 1'b0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        ITER: begin
          r     <= t[8] ? rs[7:0] : t[7:0];
          mq    <= {mq[6:0], ~t[8]};
          cnt   <= cnt + 3'd1;
          state <= (cnt == 3'd7) ? FIX : ITER;
        end
        FIX: begin
          Quotient  <= dz ? 8'h00 : ((sd ^ sv) ? -mq : mq);
          Remainder <= dz ? dvd : (sd ? -r : r);
          DivByZero <= dz;
          Overflow  <= ovf;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          state     <= DONE;
        end
        default: begin
          if (Start) begin
            sd    <= Dividend[7];
            sv    <= Divisor[7];
            mq    <= Dividend[7] ? -Dividend : Dividend;
            md    <= Divisor[7] ? -Divisor : Divisor;
            dvd   <= Dividend;
            dz    <= (Divisor == 8'h00);
            ovf   <= (Dividend == 8'h80) && (Divisor == 8'hFF);
            r     <= 8'h00;
            cnt   <= 3'd0;
            Done  <= 1'b0;
            Busy  <= 1'b1;
            state <= (Divisor == 8'h00) ? FIX : ITER;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: randomized and directed checks of signed_divider against a truncating model
module tb_signed_divider;
  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] Dividend = 8'h00;
  logic [7:0] Divisor = 8'h00;
  logic [7:0] Quotient, Remainder;
  logic       Done, Busy, DivByZero, Overflow;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] prev_q = 8'h00;
  int         lat;

  signed_divider dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder), .Done(Done), .Busy(Busy),
    .DivByZero(DivByZero), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {quotient, remainder, divbyzero, overflow} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, q, r;
    logic [7:0] q8, r8;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {8'h00, a, 1'b1, 1'b0};
    q = sa / sb;
    r = sa % sb;
    q8 = q[7:0];
    r8 = r[7:0];
    return {q8, r8, 1'b0, (sa == -128 && sb == -1)};
  endfunction

  function automatic logic [31:0] outs();
    return {12'h0, Busy, Done, Quotient, Remainder, DivByZero, Overflow};
  endfunction

  task automatic wait_done(inout int n);
    while (!Done && n < 30) begin
      @(posedge Clock);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [17:0] e;
    e = model(a, b);
    @(negedge Clock);
    Dividend = a;
    Divisor = b;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    check({tag, " launch"}, {30'h0, Busy, Done}, 32'h2);
    check({tag, " hold"}, {24'h0, Quotient}, {24'h0, prev_q});
    lat = 0;
    wait_done(lat);
    check({tag, " latency"}, lat, (b == 8'h00) ? 1 : 9);
    check({tag, " result"}, outs(), {12'h0, 2'b01, e});
    prev_q = e[17:10];
  endtask

  initial begin
    #2;
    check("reset outputs", outs(), 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    run("100/7", 8'd100, 8'd7);
    run("-100/7", 8'h9C, 8'd7);
    run("100/-7", 8'd100, 8'hF9);
    run("-100/-7", 8'h9C, 8'hF9);
    run("-128/-1", 8'h80, 8'hFF);
    run("-128/1", 8'h80, 8'h01);
    run("127/-128", 8'h7F, 8'h80);
    run("5/0", 8'h05, 8'h00);
    run("-128/0", 8'h80, 8'h00);
    run("0/3", 8'h00, 8'h03);
    check("known q 100/7", {24'h0, model(8'd100, 8'd7)}, {14'h0, 8'h0E, 8'h02, 2'b00});
    // Start during ITER must not disturb the running division
    @(negedge Clock);
    Dividend = 8'd100;
    Divisor = 8'd7;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Dividend = 8'hCE;
    Divisor = 8'd3;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    lat = 4;
    wait_done(lat);
    check("ignored start latency", lat, 9);
    check("ignored start result", outs(), {12'h0, 2'b01, model(8'd100, 8'd7)});
    // reset mid-iteration aborts and clears everything
    @(negedge Clock);
    Dividend = 8'h9C;
    Divisor = 8'd7;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("async reset outputs", outs(), 32'h0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (12) @(posedge Clock);
    #1;
    check("no done after reset", outs(), 32'h0);
    prev_q = 8'h00;
    run("100/7 after reset", 8'd100, 8'd7);
    for (int i = 0; i < 2500; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      run("random", a, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
